sub_64_pipe: RTL and testbench

- Pipelined 64-bit subtractor: diff = in1 - in2 - bin, plus borrow-out, signed-overflow and zero flags.
- It is the inverse-direction companion to the team's 64-bit carry-select adder.
- Operands are split into equal slices, one slice per pipeline stage. Each stage is carry-select: both borrow-in cases are computed, and the registered borrow from the previous stage selects one.
- Sits in the datapath between the operand-issue logic and the result writeback.
- Uses a valid/ready handshake on both sides, with full-pipeline stall on backpressure.

---
 rtl/sub_64_pipe_if.sv | 27 ++
 rtl/sub_64_pipe.sv | 117 +++++++++++
 tb/tb_sub_64_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sub_64_pipe_if.sv
// Handshake and operand/result bundle for the pipelined subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface sub_64_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in1, in2, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, in1, in2, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/sub_64_pipe.sv
// Pipelined carry-select subtractor: one operand slice per stage, registered borrow chain.
// The whole pipe freezes on backpressure; WIDTH must be a multiple of STAGES.
module sub_64_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic          clk,
    input logic          reset,
    sub_64_pipe_if.slave io
);
    localparam int SW = WIDTH / STAGES;

    logic advance;
    logic out_valid;

    assign advance     = !out_valid || io.out_ready;
    assign io.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int RW = (k + 1) * SW;

        logic          v_q;
        logic          br_q;
        logic [RW-1:0] res_q;

        logic          v_next;
        logic [SW-1:0] a_s;
        logic [SW-1:0] b_s;
        logic          bsel;
        logic [SW:0]   d0;
        logic [SW:0]   d1;
        logic [SW-1:0] d_s;
        logic          bo;
        logic [RW-1:0] res_next;

        if (k == 0) begin : src
            assign v_next   = io.in_valid;
            assign a_s      = io.in1[SW-1:0];
            assign b_s      = io.in2[SW-1:0];
            assign bsel     = io.bin;
            assign res_next = d_s;
        end else begin : src
            assign v_next   = stg[k-1].v_q;
            assign a_s      = stg[k-1].sk.ska_q[SW-1:0];
            assign b_s      = stg[k-1].sk.skb_q[SW-1:0];
            assign bsel     = stg[k-1].br_q;
            assign res_next = {d_s, stg[k-1].res_q};
        end

        // Both borrow-in cases are ready before the previous slice's borrow picks one.
        assign d0        = {1'b0, a_s} - {1'b0, b_s};
        assign d1        = {1'b0, a_s} - {1'b0, b_s} - {{SW{1'b0}}, 1'b1};
        assign {bo, d_s} = bsel ? d1 : d0;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q   <= 1'b0;
                br_q  <= 1'b0;
                res_q <= '0;
            end else if (advance) begin
                v_q   <= v_next;
                br_q  <= bo;
                res_q <= res_next;
            end
        end

        if (k < STAGES - 1) begin : sk
            localparam int KW = (STAGES - 1 - k) * SW;

            logic [KW-1:0] ska_q;
            logic [KW-1:0] skb_q;
            logic [KW-1:0] ska_next;
            logic [KW-1:0] skb_next;

            if (k == 0) begin : nx
                assign ska_next = io.in1[WIDTH-1:SW];
                assign skb_next = io.in2[WIDTH-1:SW];
            end else begin : nx
                assign ska_next = stg[k-1].sk.ska_q[(STAGES-k)*SW-1:SW];
                assign skb_next = stg[k-1].sk.skb_q[(STAGES-k)*SW-1:SW];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ska_q <= '0;
                    skb_q <= '0;
                end else if (advance) begin
                    ska_q <= ska_next;
                    skb_q <= skb_next;
                end
            end
        end

        if (k == STAGES - 1) begin : fin
            logic ovf_q;
            logic zero_q;

            // The top slice operands here still carry the original sign bits.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= (a_s[SW-1] != b_s[SW-1]) && (d_s[SW-1] != a_s[SW-1]);
                    zero_q <= ~|res_next;
                end
            end
        end
    end

    assign out_valid    = stg[STAGES-1].v_q;
    assign io.out_valid = out_valid;
    assign io.diff      = stg[STAGES-1].res_q;
    assign io.bout      = stg[STAGES-1].br_q;
    assign io.ovf       = stg[STAGES-1].fin.ovf_q;
    assign io.zero      = stg[STAGES-1].fin.zero_q;
endmodule

// File: tb/tb_sub_64_pipe.sv
// Bench for sub_64_pipe: directed and random beats against an arithmetic model
// tracked through an occupancy model of the frozen-on-stall pipe.
module tb_sub_64_pipe;
    localparam int W = 64;
    localparam int S = 4;

    typedef struct packed {
        logic          v;
        logic [W-1:0]  diff;
        logic          bout;
        logic          ovf;
        logic          zero;
    } slot_t;

    logic  clk = 1'b0;
    logic  reset;
    slot_t pipe [S];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_out = 0;

    always #5 clk = ~clk;

    sub_64_pipe_if #(.WIDTH(W)) bus ();

    sub_64_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    function automatic slot_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        slot_t    r;
        logic [W:0] full;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        r.v    = 1'b1;
        r.diff = full[W-1:0];
        r.bout = full[W];
        r.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < S; i++) pipe[i] = '0;
    endtask

    // Compares the DUT against the model slot at the output end before the edge.
    task automatic checkOutput(input logic ordy);
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, pipe[S-1].v});
        chk("in_ready", {63'b0, bus.in_ready}, {63'b0, (!pipe[S-1].v || ordy)});
        if (pipe[S-1].v) begin
            chk("diff", bus.diff, pipe[S-1].diff);
            chk("bout", {63'b0, bus.bout}, {63'b0, pipe[S-1].bout});
            chk("ovf",  {63'b0, bus.ovf},  {63'b0, pipe[S-1].ovf});
            chk("zero", {63'b0, bus.zero}, {63'b0, pipe[S-1].zero});
            if (ordy) n_out++;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model with the edge.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input logic ordy, output logic accepted);
        logic adv;
        bus.in_valid  = iv;
        bus.in1       = a;
        bus.in2       = b;
        bus.bin       = bi;
        bus.out_ready = ordy;
        #1;
        checkOutput(ordy);
        adv      = !pipe[S-1].v || ordy;
        accepted = iv && adv;
        if (adv) begin
            for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0]   = model(a, b, bi);
            pipe[0].v = iv;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, acc);
    endtask

    task automatic checkResetState();
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'b0, bus.in_ready},  64'd1);
        chk("rst_diff", bus.diff, 64'd0);
        chk("rst_bout", {63'b0, bus.bout}, 64'd0);
        chk("rst_ovf",  {63'b0, bus.ovf},  64'd0);
        chk("rst_zero", {63'b0, bus.zero}, 64'd0);
    endtask

    initial begin
        logic acc;
        int   j;
        int   cyc;
        int   out_before;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        clearModel();
        #1;
        checkResetState();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single beat and directed corners");
        applyStimulus(1'b1, 64'h5, 64'h3, 1'b0, 1'b1, acc);
        chk("accept_1", {63'b0, acc}, 64'd1);
        idle(S + 1);
        applyStimulus(1'b1, 64'h0, 64'h0, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, acc);
        idle(S + 1);

        $display("[TB] back-to-back streaming");
        out_before = n_out;
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, acc);
        idle(S + 1);
        chk("stream_count", 64'(n_out - out_before), 64'd16);

        $display("[TB] backpressure");
        out_before = n_out;
        j   = 0;
        cyc = 0;
        while (j < 8 && cyc < 100) begin
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                          !(cyc >= 6 && cyc < 9), acc);
            if (acc) j++;
            cyc++;
        end
        chk("bp_accepted", 64'(j), 64'd8);
        idle(S + 1);
        chk("bp_count", 64'(n_out - out_before), 64'd8);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, acc);
        reset = 1'b1;
        #1;
        checkResetState();
        clearModel();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 64'hA, 64'hA, 1'b0, 1'b1, acc);
        idle(S + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
